// File: rtl/axil_sram_ctrl_param.sv
// axil_sram_ctrl_param: AXI4-Lite slave to single-port req/done SRAM bridge with round-robin read/write arbitration.
// Define SRAM_TIMEOUT_EN to abort SRAM requests that see no done within TIMEOUT_CYC cycles.
module axil_sram_ctrl_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRAM_DEPTH = 1024,
  parameter int TIMEOUT_CYC = 64,
  localparam int STRB_W = DATA_W / 8,
  localparam int BOFF = $clog2(STRB_W),
  localparam int SRAM_AW = $clog2(SRAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [STRB_W-1:0]   s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [DATA_W-1:0]   sram_data_in,
  output logic [STRB_W-1:0]   sram_be,
  output logic                wr_en,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   sram_data_out,
  input  logic                sram_write_done,
  input  logic                sram_read_done
);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(SRAM_DEPTH * STRB_W);
  if (TIMEOUT_CYC < 1 || SRAM_DEPTH < 2 || (DATA_W != 32 && DATA_W != 64)) begin : g_bad_param
    $error("axil_sram_ctrl_param: unsupported parameter set");
  end
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;
  state_t state, state_d;
  logic aw_full, w_full, ar_full, last_wr, tmo;
  logic aw_full_d, w_full_d, ar_full_d;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic aw_oor, ar_oor, grant_wr, grant_rd, take_wr, take_rd;
  assign aw_oor = aw_addr >= LIMIT;
  assign ar_oor = ar_addr >= LIMIT;
  // last_wr=0 means the read side was served last, so a write wins the next tie
  assign grant_wr = aw_full && w_full && (!ar_full || !last_wr);
  assign grant_rd = ar_full && !grant_wr;
  assign take_wr = state == IDLE && grant_wr;
  assign take_rd = state == IDLE && grant_rd;
  assign aw_full_d = (aw_full || (s_axi_awvalid && s_axi_awready)) && !take_wr;
  assign w_full_d = (w_full || (s_axi_wvalid && s_axi_wready)) && !take_wr;
  assign ar_full_d = (ar_full || (s_axi_arvalid && s_axi_arready)) && !take_rd;
`ifdef SRAM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= (state_d != state || !(state == WR_REQ || state == RD_REQ)) ? '0 : tcnt + 1'b1;
  assign tmo = tcnt == CW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = grant_wr ? ((aw_oor || w_strb == '0) ? WR_RESP : WR_REQ)
                       : grant_rd ? (ar_oor ? RD_RESP : RD_REQ) : IDLE;
      WR_REQ:  state_d = (sram_write_done || tmo) ? WR_RESP : WR_REQ;
      RD_REQ:  state_d = (sram_read_done || tmo) ? RD_RESP : RD_REQ;
      WR_RESP: state_d = s_axi_bready ? IDLE : WR_RESP;
      RD_RESP: state_d = s_axi_rready ? IDLE : RD_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {aw_full, w_full, ar_full, last_wr} <= '0;
      {s_axi_awready, s_axi_wready, s_axi_arready} <= '0;
      {aw_addr, ar_addr, w_data, w_strb} <= '0;
      {wr_en, rd_en, s_axi_bvalid, s_axi_rvalid} <= '0;
      {sram_addr, sram_data_in, sram_be} <= '0;
      {s_axi_bresp, s_axi_rresp, s_axi_rdata} <= '0;
    end else begin
      aw_full <= aw_full_d;
      w_full <= w_full_d;
      ar_full <= ar_full_d;
      s_axi_awready <= !aw_full_d;
      s_axi_wready <= !w_full_d;
      s_axi_arready <= !ar_full_d;
      if (s_axi_awvalid && s_axi_awready) aw_addr <= s_axi_awaddr;
      if (s_axi_wvalid && s_axi_wready) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) ar_addr <= s_axi_araddr;
      wr_en <= state_d == WR_REQ;
      rd_en <= state_d == RD_REQ;
      s_axi_bvalid <= state_d == WR_RESP;
      s_axi_rvalid <= state_d == RD_RESP;
      if (take_wr) begin
        last_wr <= 1'b1;
        sram_addr <= aw_addr[BOFF+SRAM_AW-1:BOFF];
        sram_data_in <= w_data;
        sram_be <= w_strb;
        s_axi_bresp <= aw_oor ? SLVERR : OKAY;
      end
      if (take_rd) begin
        last_wr <= 1'b0;
        sram_addr <= ar_addr[BOFF+SRAM_AW-1:BOFF];
        s_axi_rdata <= '0;
        s_axi_rresp <= ar_oor ? SLVERR : OKAY;
      end
      if (state == WR_REQ && state_d == WR_RESP) s_axi_bresp <= sram_write_done ? OKAY : SLVERR;
      if (state == RD_REQ && state_d == RD_RESP) begin
        s_axi_rdata <= sram_read_done ? sram_data_out : '0;
        s_axi_rresp <= sram_read_done ? OKAY : SLVERR;
      end
    end
  end
endmodule

// File: tb/tb_axil_sram_ctrl_param.sv
// tb_axil_sram_ctrl_param: directed bench for axil_sram_ctrl_param with a latency-configurable SRAM model.
module tb_axil_sram_ctrl_param;
  logic clk = 0, rst_n = 0;
  logic [31:0] s_axi_awaddr = 0, s_axi_wdata = 0, s_axi_araddr = 0;
  logic [3:0] s_axi_wstrb = 0;
  logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_arvalid = 0, s_axi_bready = 0, s_axi_rready = 0;
  logic s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, sram_data_in;
  logic [31:0] sram_data_out = 0;
  logic [9:0] sram_addr;
  logic [3:0] sram_be;
  logic wr_en, rd_en;
  logic sram_write_done = 0, sram_read_done = 0;
  int checks = 0, errors = 0;
  int lat = 0, cnt = 0;
  bit mute = 0;
  logic [31:0] mem [0:1023];

  axil_sram_ctrl_param #(.DATA_W(32), .ADDR_W(32), .SRAM_DEPTH(1024), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_be(sram_be), .wr_en(wr_en), .rd_en(rd_en),
    .sram_data_out(sram_data_out), .sram_write_done(sram_write_done), .sram_read_done(sram_read_done)
  );

  always #5 clk = ~clk;

  // SRAM model: completes a request lat+1 cycles after it first sees it; mute never completes
  always @(posedge clk) begin
    sram_write_done <= 1'b0;
    sram_read_done <= 1'b0;
    if (!mute && (wr_en || rd_en) && !sram_write_done && !sram_read_done) begin
      if (cnt >= lat) begin
        cnt <= 0;
        if (wr_en) begin
          for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][b*8+:8] <= sram_data_in[b*8+:8];
          sram_write_done <= 1'b1;
        end else begin
          sram_data_out <= mem[sram_addr];
          sram_read_done <= 1'b1;
        end
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end

  task automatic send(input bit do_aw, input bit do_w, input bit do_ar, input logic [31:0] aa,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra);
    s_axi_awaddr = aa; s_axi_wdata = wd; s_axi_wstrb = ws; s_axi_araddr = ra;
    s_axi_awvalid = do_aw; s_axi_wvalid = do_w; s_axi_arvalid = do_ar;
    for (int n = 0; n < 50 && (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid); n++) begin
      bit a, w, r;
      a = s_axi_awvalid && s_axi_awready;
      w = s_axi_wvalid && s_axi_wready;
      r = s_axi_arvalid && s_axi_arready;
      @(negedge clk);
      if (a) s_axi_awvalid = 0;
      if (w) s_axi_wvalid = 0;
      if (r) s_axi_arvalid = 0;
    end
    if (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) begin
      checks++; errors++;
      $display("FAIL send_handshake: valids still pending aw=%b w=%b ar=%b, required all accepted", s_axi_awvalid, s_axi_wvalid, s_axi_arvalid);
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    end
  endtask

  task automatic wait_b(output logic [1:0] resp, output bit saw_wr);
    int n = 0;
    saw_wr = 0;
    s_axi_bready = 1;
    while (!s_axi_bvalid && n < 200) begin
      if (wr_en) saw_wr = 1;
      @(negedge clk);
      n++;
    end
    resp = s_axi_bresp;
    if (!s_axi_bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid=0 after %0d cycles, required 1", n);
      resp = 2'bxx;
    end
    @(negedge clk);
    s_axi_bready = 0;
  endtask

  task automatic wait_r(output logic [1:0] resp, output logic [31:0] data);
    int n = 0;
    s_axi_rready = 1;
    while (!s_axi_rvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    resp = s_axi_rresp;
    data = s_axi_rdata;
    if (!s_axi_rvalid) begin
      checks++; errors++;
      $display("FAIL r_timeout: rvalid=0 after %0d cycles, required 1", n);
      resp = 2'bxx;
    end
    @(negedge clk);
    s_axi_rready = 0;
  endtask

  task automatic test_reset();
    logic [6:0] st;
    repeat (3) @(negedge clk);
    st = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wr_en, rd_en};
    checks++; if (st !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b, required 0000000", st); end
    checks++; if ({sram_addr, sram_be, s_axi_rdata} !== 46'b0) begin errors++; $display("FAIL reset_data: addr=%h be=%h rdata=%h, required 0", sram_addr, sram_be, s_axi_rdata); end
    rst_n = 1;
    @(negedge clk);
    st = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wr_en, rd_en};
    checks++; if (st !== 7'b1110000) begin errors++; $display("FAIL reset_release: got %b, required 1110000", st); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] data; bit saw;
    lat = 3;
    send(0, 1, 0, 0, 32'hDEADBEEF, 4'hF, 0);
    repeat (2) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL w_only_no_req: wr_en=%b, required 0", wr_en); end
    send(1, 0, 0, 32'h10, 0, 0, 0);
    for (int n = 0; n < 20 && !wr_en; n++) @(negedge clk);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL wba_wr_en: got %b, required 1", wr_en); end
    checks++; if (sram_addr !== 10'd4) begin errors++; $display("FAIL wba_addr: got %0d, required 4", sram_addr); end
    checks++; if (sram_be !== 4'hF) begin errors++; $display("FAIL wba_be: got %h, required f", sram_be); end
    checks++; if (sram_data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL wba_data: got %h, required deadbeef", sram_data_in); end
    wait_b(resp, saw);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wba_bresp: got %b, required 00", resp); end
    send(0, 0, 1, 0, 0, 0, 32'h10);
    wait_r(resp, data);
    checks++; if (resp !== 2'b00 || data !== 32'hDEADBEEF) begin errors++; $display("FAIL wba_read: resp=%b data=%h, required 00 deadbeef", resp, data); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] data; bit saw;
    lat = 1;
    send(1, 1, 0, 32'h20, 32'hAABBCCDD, 4'hF, 0);
    wait_b(resp, saw);
    send(1, 1, 0, 32'h20, 32'h11223344, 4'h5, 0);
    for (int n = 0; n < 20 && !wr_en; n++) @(negedge clk);
    checks++; if (sram_be !== 4'h5 || wr_en !== 1'b1) begin errors++; $display("FAIL strobe_be: be=%h wr_en=%b, required 5 1", sram_be, wr_en); end
    wait_b(resp, saw);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL strobe_bresp: got %b, required 00", resp); end
    send(0, 0, 1, 0, 0, 0, 32'h20);
    wait_r(resp, data);
    checks++; if (data !== 32'hAA22CC44) begin errors++; $display("FAIL strobe_merge: got %h, required aa22cc44", data); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] data; bit saw;
    lat = 0;
    send(1, 1, 0, 32'h1000, 32'h1, 4'hF, 0);
    wait_b(resp, saw);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b, required 10", resp); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL oor_no_wr: wr_en seen=%b, required 0", saw); end
    send(1, 1, 0, 32'h30, 32'h2, 4'h0, 0);
    wait_b(resp, saw);
    checks++; if (resp !== 2'b00 || saw !== 1'b0) begin errors++; $display("FAIL zero_strb: resp=%b wr_en seen=%b, required 00 0", resp, saw); end
    send(0, 0, 1, 0, 0, 0, 32'h1000);
    wait_r(resp, data);
    checks++; if (resp !== 2'b10 || data !== 32'h0) begin errors++; $display("FAIL oor_read: resp=%b data=%h, required 10 00000000", resp, data); end
    send(0, 0, 1, 0, 0, 0, 32'hFFC);
    wait_r(resp, data);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL last_word_read: resp=%b, required 00", resp); end
  endtask

  task automatic test_arbitration();
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      int seq [2];
      int k = 0;
      bit pw = 0, pr = 0, got_b = 0, got_r = 0;
      logic [31:0] rd = 0;
      seq[0] = 0; seq[1] = 0;
      s_axi_bready = 1; s_axi_rready = 1;
      send(1, 1, 1, 32'h40, 32'h1000 + i, 4'hF, 32'h40);
      for (int n = 0; n < 100 && !(got_b && got_r); n++) begin
        if (wr_en && !pw && k < 2) begin seq[k] = 1; k++; end
        if (rd_en && !pr && k < 2) begin seq[k] = 2; k++; end
        pw = wr_en; pr = rd_en;
        if (s_axi_bvalid) got_b = 1;
        if (s_axi_rvalid) begin got_r = 1; rd = s_axi_rdata; end
        @(negedge clk);
      end
      s_axi_bready = 0; s_axi_rready = 0;
      checks++; if (seq[0] != 1 || seq[1] != 2) begin errors++; $display("FAIL arb_order[%0d]: got %0d,%0d, required 1,2 (1=W 2=R)", i, seq[0], seq[1]); end
      checks++; if (!(got_b && got_r)) begin errors++; $display("FAIL arb_complete[%0d]: b=%b r=%b, required 1 1", i, got_b, got_r); end
      checks++; if (rd !== 32'h1000 + i) begin errors++; $display("FAIL arb_data[%0d]: got %h, required %h", i, rd, 32'h1000 + i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [31:0] data; bit saw;
    lat = 0;
    s_axi_bready = 0;
    send(1, 1, 0, 32'h50, 32'hCAFEF00D, 4'hF, 0);
    for (int n = 0; n < 50 && !s_axi_bvalid; n++) @(negedge clk);
    send(1, 1, 0, 32'h60, 32'h12345678, 4'hF, 0);
    checks++; if ({s_axi_awready, s_axi_wready} !== 2'b00) begin errors++; $display("FAIL bp_ready_drop: aw/wready=%b, required 00", {s_axi_awready, s_axi_wready}); end
    for (int c = 0; c < 5; c++) begin
      checks++; if ({s_axi_bvalid, s_axi_bresp, wr_en} !== 4'b1000) begin errors++; $display("FAIL bp_hold[%0d]: bvalid,bresp,wr_en=%b, required 1000", c, {s_axi_bvalid, s_axi_bresp, wr_en}); end
      @(negedge clk);
    end
    wait_b(resp, saw);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL bp_first_bresp: got %b, required 00", resp); end
    wait_b(resp, saw);
    checks++; if (resp !== 2'b00 || saw !== 1'b1) begin errors++; $display("FAIL bp_second_write: resp=%b wr_en seen=%b, required 00 1", resp, saw); end
    checks++; if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: awready=%b, required 1", s_axi_awready); end
    send(0, 0, 1, 0, 0, 0, 32'h60);
    wait_r(resp, data);
    checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL bp_readback: got %h, required 12345678", data); end
  endtask

  // Model answers one cycle after the request appears, so bvalid lands in cycle 4 here
  task automatic test_min_latency();
    lat = 0;
    s_axi_bready = 0;
    checks++; if ({s_axi_awready, s_axi_wready} !== 2'b11) begin errors++; $display("FAIL lat_ready: got %b, required 11", {s_axi_awready, s_axi_wready}); end
    s_axi_awaddr = 32'h70; s_axi_wdata = 32'h0BADCAFE; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL lat_c1: wr_en=%b, required 0", wr_en); end
    @(negedge clk);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL lat_c2: wr_en=%b, required 1", wr_en); end
    @(negedge clk);
    checks++; if ({wr_en, s_axi_bvalid} !== 2'b10) begin errors++; $display("FAIL lat_c3: wr_en,bvalid=%b, required 10", {wr_en, s_axi_bvalid}); end
    @(negedge clk);
    checks++; if ({wr_en, s_axi_bvalid} !== 2'b01) begin errors++; $display("FAIL lat_c4: wr_en,bvalid=%b, required 01", {wr_en, s_axi_bvalid}); end
    s_axi_bready = 1;
    @(negedge clk);
    s_axi_bready = 0;
  endtask

`ifdef SRAM_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] resp; logic [31:0] data;
    int n = 0;
    mute = 1;
    send(0, 0, 1, 0, 0, 0, 32'h80);
    for (int m = 0; m < 20 && !rd_en; m++) @(negedge clk);
    while (rd_en && n < 50) begin n++; @(negedge clk); end
    checks++; if (n != 8) begin errors++; $display("FAIL tmo_cycles: rd_en high %0d cycles, required 8", n); end
    wait_r(resp, data);
    checks++; if (resp !== 2'b10 || data !== 32'h0) begin errors++; $display("FAIL tmo_resp: resp=%b data=%h, required 10 00000000", resp, data); end
    mute = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_w_before_aw();
    test_strobe();
    test_out_of_range();
    test_arbitration();
    test_back_to_back();
    test_min_latency();
`ifdef SRAM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_sram_ctrl_param.md
Name: axil_sram_ctrl_param

Overview:
Parametrised AXI4-Lite slave to single-port SRAM controller, successor to the fixed 32-bit SRAM-lite controller. Generalises data width and SRAM depth and drives SRAM byte enables from WSTRB. Accepts AW and W in either order and arbitrates reads and writes round-robin. Returns SLVERR for out-of-range addresses. Sits between the AXI-Lite interconnect and an SRAM macro wrapper that uses a req/done handshake.

Parameters:
DATA_W, 32, AXI and SRAM data width; 32 or 64 only
ADDR_W, 32, AXI address width
SRAM_DEPTH, 1024, SRAM words; any value >= 2
TIMEOUT_CYC, 64, SRAM wait limit in cycles (used only with the optional feature)
Derived: STRB_W=DATA_W/8, BOFF=$clog2(STRB_W), SRAM_AW=$clog2(SRAM_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  AW channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/STRB_W/1/1  W channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  B channel
s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  AR channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  R channel
sram_addr  out  SRAM_AW  word address
sram_data_in  out  DATA_W  write data
sram_be  out  STRB_W  byte enables
wr_en / rd_en  out  1/1  SRAM request levels
sram_data_out  in  DATA_W  read data, valid when sram_read_done=1
sram_write_done / sram_read_done  in  1/1  SRAM completion pulses

Behaviour:
- Reset: all outputs 0, FSM=IDLE, holding flags cleared, last_grant=read, so a write wins the first tie. All readies, valids and SRAM outputs are registered. aw/w/arready go to 1 on the first clock after rst_n rises.
- Holding registers: AW, W and AR each have an independent holding register and flag. A channel's ready = !flag, so a channel accepts one beat and then deasserts ready until that beat is consumed. AW and W may arrive in any order or in the same cycle.
- Word index = addr[BOFF+SRAM_AW-1:BOFF]. addr[BOFF-1:0] is ignored. An address is out-of-range if addr >= SRAM_DEPTH*STRB_W.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE:
  - write pending = AW and W both held; read pending = AR held.
  - If both are pending, grant the opposite of last_grant; otherwise grant the one pending.
  - Out-of-range, or write with wstrb==0: skip SRAM, go directly to the RESP state. bresp=SLVERR for out-of-range, OKAY for zero strobes. rresp=SLVERR with rdata=0.
  - Otherwise go to WR_REQ / RD_REQ with sram_addr, sram_data_in and sram_be loaded.
  - Clear the consumed holding flags on leaving IDLE; ready reasserts the next cycle.
- WR_REQ / RD_REQ: wr_en/rd_en held at 1 until the done pulse is sampled. The request drops the cycle after done. On read done, capture sram_data_out into rdata. Then go to RESP.
- WR_RESP / RD_RESP: bvalid/rvalid=1 with resp (OKAY=00, SLVERR=10) until bready/rready is sampled 1, then IDLE. Update last_grant.
- Minimum latency, write with both beats in cycle 0 and SRAM done in the first request cycle: wr_en at cycle 2, bvalid at cycle 3.
- The response payload stays stable while valid and ready=0.
- New AW/W/AR beats may be accepted into empty holding registers in any state.
- Asynchronous reset mid-transaction aborts immediately. Done pulses arriving outside the REQ states are ignored.

Optional Feature:
SRAM_TIMEOUT_EN.
- Defined: a counter runs in WR_REQ/RD_REQ. If no done arrives after TIMEOUT_CYC request cycles, drop the request and move to RESP with SLVERR (rdata=0). The counter clears on each state entry.
- Undefined: no counter logic is present, and the FSM waits indefinitely for done.

Test Plan:
- W(0xDEADBEEF, strb 0xF) two cycles before AW(0x10), done after 3 cycles -> wr_en, sram_addr=4, be=0xF, then bresp=OKAY. Read of 0x10 -> rdata=0xDEADBEEF, OKAY.
- Write 0x11223344 with strb 0x5 to 0x20 -> sram_be=0x5. SRAM model read-back of 0x20 shows only bytes 0 and 2 updated.
- AW 0x1000 with DEPTH=1024, DATA_W=32 (limit 0x1000) -> no wr_en, bresp=SLVERR. AR 0xFFC -> OKAY.
- Write and read pending in the same IDLE cycle, repeated 4 times -> grants W,R,W,R, each completing in order.
- Hold bready=0 for 5 cycles -> bvalid/bresp stable. A new AW is accepted once (awready drops); no second SRAM access until B completes.
- With SRAM_TIMEOUT_EN defined and TIMEOUT_CYC=8, SRAM never responds to a read -> rd_en drops after 8 cycles, rresp=SLVERR, rdata=0.
